// File: rtl/mem_read_arbiter.sv
// Two-master round-robin arbiter for a single AXI-style read channel.
// One burst is outstanding at a time; data beats route to the granted master.
module mem_read_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 5,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [LEN_WIDTH-1:0]  m0_arlen,
  input  logic [ID_WIDTH-1:0]   m0_arid,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [LEN_WIDTH-1:0]  m1_arlen,
  input  logic [ID_WIDTH-1:0]   m1_arid,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  output logic [LEN_WIDTH-1:0]  mem_arlen,
  output logic [ID_WIDTH-1:0]   mem_arid,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  output logic                  busy,
  output logic                  protocol_err,
  output logic [1:0]            state_dbg
);

  // Handshakes: a transfer on any channel happens on the posedge where
  // valid and ready are both high; valid never waits on ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               state;
  logic                 grant;
  logic                 prefer;
  logic [LEN_WIDTH-1:0] count;
  logic                 pick;
  logic                 in_addr;
  logic                 in_data;
  logic                 beat;

  // Preferred master wins a tie; otherwise whoever is requesting.
  assign pick = (m0_arvalid && m1_arvalid) ? prefer : m1_arvalid;

  // Combinational paths are forced low while rst is high so the reset
  // cycle itself never routes a beat or accepts an address.
  assign in_addr = !rst && (state == ADDR);
  assign in_data = !rst && (state == DATA);

  assign m0_arready   = in_addr && !grant && mem_arready;
  assign m1_arready   = in_addr &&  grant && mem_arready;
  assign mem_rready   = in_data && (grant ? m1_rready : m0_rready);
  assign m0_rvalid    = in_data && !grant && mem_rvalid;
  assign m1_rvalid    = in_data &&  grant && mem_rvalid;
  assign m0_rdata     = rst ? '0 : mem_rdata;
  assign m1_rdata     = rst ? '0 : mem_rdata;
  assign beat         = in_data && mem_rvalid && mem_rready;
  assign busy         = !rst && (state != IDLE);
  assign protocol_err = !rst && mem_rvalid && (state != DATA);
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      prefer      <= 1'b0;
      count       <= '0;
      mem_araddr  <= '0;
      mem_arlen   <= '0;
      mem_arid    <= '0;
      mem_arvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            grant       <= pick;
            mem_araddr  <= pick ? m1_araddr : m0_araddr;
            mem_arlen   <= pick ? m1_arlen  : m0_arlen;
            mem_arid    <= pick ? m1_arid   : m0_arid;
            mem_arvalid <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            // A zero length is treated as a single beat.
            count       <= (mem_arlen == '0) ? LEN_WIDTH'(1) : mem_arlen;
            prefer      <= ~grant;
            state       <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            count <= count - LEN_WIDTH'(1);
            if (count == LEN_WIDTH'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
